// File: rtl/tuner_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : tuner_ctrl_if
//  Purpose  : Signal bundle between the peak-detector/switch side and the
//             tuner sequencer, including the comparator configuration outputs.
//  Modports : master - drives peak_valid, peak, auto_mode, manual_string;
//                      observes the comparator configuration and status.
//             slave  - the sequencer side (tuner_ctrl).
//  Revision : 1.0 - initial release
// ============================================================================
interface tuner_ctrl_if;
   logic       peak_valid;
   logic [9:0] peak;
   logic       auto_mode;
   logic [2:0] manual_string;
   logic [9:0] peak_out;
   logic [9:0] target;
   logic [9:0] tolerance;
   logic [9:0] vf_th;
   logic [9:0] jf_th;
   logic [9:0] js_th;
   logic [9:0] vs_th;
   logic       new_dom_freq;
   logic [2:0] string_idx;
   logic       signal_lost;
   logic [2:0] ctrl_state;

   modport master (
      output peak_valid, peak, auto_mode, manual_string,
      input  peak_out, target, tolerance, vf_th, jf_th, js_th, vs_th,
             new_dom_freq, string_idx, signal_lost, ctrl_state
   );

   modport slave (
      input  peak_valid, peak, auto_mode, manual_string,
      output peak_out, target, tolerance, vf_th, jf_th, js_th, vs_th,
             new_dom_freq, string_idx, signal_lost, ctrl_state
   );
endinterface
`default_nettype wire

// File: rtl/tuner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tuner_ctrl
//  Purpose  : Sequencer between the FFT peak detector and the tuning
//             comparator. Filters peak samples, waits for a stable pitch,
//             selects a guitar string (auto nearest or manual), loads the
//             comparator configuration and issues the new_dom_freq strobe.
//             Declares signal loss after TIMEOUT_CYCLES without a sample.
//  Ports    : clk     - system clock
//             reset_n - asynchronous active-low reset
//             tc_io   - tuner_ctrl_if.slave (peak input, mode switches,
//                       comparator configuration, strobe and status)
//  Revision : 1.0 - initial release
// ============================================================================
module tuner_ctrl #(
   parameter int TOL            = 5,
   parameter int JF_TH          = 10,
   parameter int VF_TH          = 20,
   parameter int JS_TH          = 10,
   parameter int VS_TH          = 20,
   parameter int MIN_PEAK       = 60,
   parameter int MAX_PEAK       = 400,
   parameter int STABLE_DELTA   = 3,
   parameter int STABLE_COUNT   = 4,
   parameter int TRACK_WIN      = 40,
   parameter int TIMEOUT_CYCLES = 25_000_000
) (
   input  wire logic    clk,
   input  wire logic    reset_n,
   tuner_ctrl_if.slave  tc_io
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACQUIRE = 3'd1,
      S_SELECT  = 3'd2,
      S_ISSUE   = 3'd3,
      S_TRACK   = 3'd4
   } state_t;

   localparam logic [9:0]  MIN_PEAK_V  = 10'(MIN_PEAK);
   localparam logic [9:0]  MAX_PEAK_V  = 10'(MAX_PEAK);
   localparam logic [9:0]  DELTA_V     = 10'(STABLE_DELTA);
   localparam logic [9:0]  WIN_V       = 10'(TRACK_WIN);
   localparam logic [7:0]  STABLE_V    = 8'(STABLE_COUNT);
   localparam logic [24:0] TIMER_LAST  = 25'(TIMEOUT_CYCLES - 1);

   // Open-string frequencies in Hz.
   function automatic logic [9:0] string_hz(input logic [2:0] idx);
      case (idx)
         3'd0:    string_hz = 10'd82;
         3'd1:    string_hz = 10'd110;
         3'd2:    string_hz = 10'd147;
         3'd3:    string_hz = 10'd196;
         3'd4:    string_hz = 10'd247;
         default: string_hz = 10'd330;
      endcase
   endfunction

   function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
      absdiff = (a > b) ? (a - b) : (b - a);
   endfunction

   state_t      state_q;
   logic [9:0]  prev_peak_q;
   logic [7:0]  stable_cnt_q;
   logic [24:0] timer_q;
   logic [9:0]  target_q;
   logic [9:0]  peak_out_q;
   logic [2:0]  string_idx_q;
   logic        new_dom_freq_q;
   logic        signal_lost_q;
   logic        pend_q;          // TRACK update waiting for its strobe slot
   logic        auto_q;
   logic [2:0]  manual_q;

   logic        sample_ok;
   logic        mode_chg;
   logic        timeout_hit;
   logic [9:0]  diff_prev;
   logic [9:0]  diff_tgt;
   logic [7:0]  cnt_inc;
   logic [2:0]  near_idx;
   logic [9:0]  near_diff;
   logic [9:0]  cand_diff;
   logic [2:0]  sel_idx;

   assign sample_ok   = tc_io.peak_valid && (tc_io.peak >= MIN_PEAK_V) && (tc_io.peak <= MAX_PEAK_V);
   assign mode_chg    = (tc_io.auto_mode != auto_q) || (tc_io.manual_string != manual_q);
   // An accepted sample in the expiry cycle cancels the timeout.
   assign timeout_hit = !sample_ok && (timer_q == TIMER_LAST);
   assign diff_prev   = absdiff(tc_io.peak, prev_peak_q);
   assign diff_tgt    = absdiff(tc_io.peak, target_q);
   assign cnt_inc     = stable_cnt_q + 8'd1;

   // Nearest string; strict less-than keeps the lower index on a tie.
   always_comb begin
      near_idx  = 3'd0;
      near_diff = absdiff(prev_peak_q, string_hz(3'd0));
      cand_diff = '0;
      for (int i = 1; i < 6; i++) begin
         cand_diff = absdiff(prev_peak_q, string_hz(3'(i)));
         if (cand_diff < near_diff) begin
            near_diff = cand_diff;
            near_idx  = 3'(i);
         end
      end
   end

   always_comb begin
      sel_idx = '0;
      if (tc_io.auto_mode)
         sel_idx = near_idx;
      else
         sel_idx = (tc_io.manual_string > 3'd5) ? 3'd5 : tc_io.manual_string;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         prev_peak_q    <= '0;
         stable_cnt_q   <= '0;
         timer_q        <= '0;
         target_q       <= 10'd82;
         peak_out_q     <= '0;
         string_idx_q   <= '0;
         new_dom_freq_q <= 1'b0;
         signal_lost_q  <= 1'b1;
         pend_q         <= 1'b0;
         auto_q         <= 1'b0;
         manual_q       <= '0;
      end else begin
         auto_q         <= tc_io.auto_mode;
         manual_q       <= tc_io.manual_string;
         new_dom_freq_q <= 1'b0;

         if (state_q != S_IDLE)
            timer_q <= sample_ok ? '0 : timer_q + 25'd1;

         if ((state_q != S_IDLE) && timeout_hit) begin
            signal_lost_q <= 1'b1;
            state_q       <= S_IDLE;
            timer_q       <= '0;
            stable_cnt_q  <= '0;
            pend_q        <= 1'b0;
         end else if ((state_q != S_IDLE) && mode_chg) begin
            // Re-acquire from scratch; target and string_idx stay as they are.
            state_q      <= S_ACQUIRE;
            stable_cnt_q <= '0;
            pend_q       <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  timer_q <= '0;
                  if (sample_ok) begin
                     prev_peak_q   <= tc_io.peak;
                     stable_cnt_q  <= 8'd1;
                     signal_lost_q <= 1'b0;
                     state_q       <= S_ACQUIRE;
                  end
               end
               S_ACQUIRE: begin
                  if (sample_ok) begin
                     prev_peak_q <= tc_io.peak;
                     if (diff_prev <= DELTA_V) begin
                        stable_cnt_q <= cnt_inc;
                        if (cnt_inc == STABLE_V)
                           state_q <= S_SELECT;
                     end else begin
                        stable_cnt_q <= 8'd1;
                     end
                  end
               end
               S_SELECT: begin
                  string_idx_q <= sel_idx;
                  target_q     <= string_hz(sel_idx);
                  peak_out_q   <= prev_peak_q;
                  state_q      <= S_ISSUE;
               end
               S_ISSUE: begin
                  // Config was loaded last cycle, so it is settled before the strobe.
                  new_dom_freq_q <= 1'b1;
                  state_q        <= S_TRACK;
               end
               S_TRACK: begin
                  // A pending update fires unless a strobe is already high,
                  // which keeps strobes at least one cycle apart.
                  if (pend_q && !new_dom_freq_q) begin
                     new_dom_freq_q <= 1'b1;
                     pend_q         <= 1'b0;
                  end
                  if (sample_ok) begin
                     if (diff_tgt <= WIN_V) begin
                        peak_out_q <= tc_io.peak;
                        pend_q     <= 1'b1;
                     end else begin
                        prev_peak_q  <= tc_io.peak;
                        stable_cnt_q <= 8'd1;
                        pend_q       <= 1'b0;
                        state_q      <= S_ACQUIRE;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign tc_io.peak_out     = peak_out_q;
   assign tc_io.target       = target_q;
   assign tc_io.tolerance    = 10'(TOL);
   assign tc_io.vf_th        = 10'(VF_TH);
   assign tc_io.jf_th        = 10'(JF_TH);
   assign tc_io.js_th        = 10'(JS_TH);
   assign tc_io.vs_th        = 10'(VS_TH);
   assign tc_io.new_dom_freq = new_dom_freq_q;
   assign tc_io.string_idx   = string_idx_q;
   assign tc_io.signal_lost  = signal_lost_q;
   assign tc_io.ctrl_state   = state_q;

endmodule
`default_nettype wire
